// File: rtl/rf_host_cfg_sequencer.sv
// Host-side configuration sequencer for an RF transceiver MCU port: enters config
// mode, writes a C0 parameter frame, reads it back with C1 C1 C1, compares, exits.
module rf_host_cfg_sequencer #(
    parameter int unsigned MODE_SETTLE_CYCLES  = 5000,
    parameter int unsigned AUX_TIMEOUT_CYCLES  = 100000,
    parameter int unsigned RESP_TIMEOUT_CYCLES = 200000
) (
    input  logic       internal_clk,
    input  logic       rst,
    input  logic       cfg_start,
    input  logic [7:0] cfg_addh,
    input  logic [7:0] cfg_addl,
    input  logic [7:0] cfg_sped,
    input  logic [7:0] cfg_chan,
    input  logic [7:0] cfg_option,
    output logic       cfg_busy,
    output logic       cfg_done,
    output logic       cfg_ok,
    output logic [1:0] cfg_err,
    output logic       M0,
    output logic       M1,
    input  logic       AUX,
    output logic [7:0] tx_data,
    output logic       tx_use,
    input  logic       tx_full,
    input  logic [7:0] rx_data,
    input  logic       rx_flag
);

    localparam logic [7:0] CMD_WR = 8'hC0;
    localparam logic [7:0] CMD_RD = 8'hC1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WAIT_AUX0,
        S_ENTER_CFG,
        S_SEND_CFG,
        S_WAIT_WR,
        S_SEND_QRY,
        S_RECV,
        S_CHECK,
        S_EXIT_CFG,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic            aux_s1_q, aux_s2_q;
    logic [4:0][7:0] par_q, par_d;
    logic [5:0][7:0] rbuf_q, rbuf_d;
    logic [2:0]      rx_cnt_q, rx_cnt_d;
    logic [2:0]      tx_idx_q, tx_idx_d;
    logic            gap_q, gap_d;
    logic [31:0]     settle_q, settle_d;
    logic [31:0]     tmo_q, tmo_d;
    logic            m_q, m_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            ok_q, ok_d;
    logic [1:0]      err_q, err_d;

    logic            aux_sync;
    logic            settle_done;
    logic            aux_tmo;
    logic            resp_tmo;
    logic            can_send;

    function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [4:0][7:0] par);
        case (idx)
            3'd1:    frame_byte = par[0];
            3'd2:    frame_byte = par[1];
            3'd3:    frame_byte = par[2];
            3'd4:    frame_byte = par[3];
            3'd5:    frame_byte = par[4];
            default: frame_byte = CMD_WR;
        endcase
    endfunction

    assign aux_sync    = aux_s2_q;
    assign settle_done = aux_sync && (settle_q + 32'd1 >= MODE_SETTLE_CYCLES);
    assign aux_tmo     = !aux_sync && (tmo_q + 32'd1 >= AUX_TIMEOUT_CYCLES);
    assign resp_tmo    = (tmo_q + 32'd1 >= RESP_TIMEOUT_CYCLES);
    // A strobe is never issued back-to-back, nor while the UART buffer is full.
    assign can_send    = !gap_q && !tx_full;

    always_comb begin
        state_d  = state_q;
        par_d    = par_q;
        rbuf_d   = rbuf_q;
        rx_cnt_d = rx_cnt_q;
        tx_idx_d = tx_idx_q;
        gap_d    = 1'b0;
        settle_d = settle_q;
        tmo_d    = tmo_q;
        m_d      = m_q;
        err_d    = err_q;
        ok_d     = ok_q;
        tx_use   = 1'b0;
        tx_data  = 8'h00;

        case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    par_d    = {cfg_option, cfg_chan, cfg_sped, cfg_addl, cfg_addh};
                    err_d    = 2'd0;
                    ok_d     = 1'b0;
                    rx_cnt_d = 3'd0;
                    state_d  = S_WAIT_AUX0;
                end
            end
            S_WAIT_AUX0: begin
                if (!aux_sync) tmo_d = tmo_q + 32'd1;
                if (aux_tmo) begin
                    err_d   = 2'd1;
                    state_d = S_EXIT_CFG;
                end else if (aux_sync) begin
                    state_d = S_ENTER_CFG;
                end
            end
            S_ENTER_CFG, S_WAIT_WR, S_EXIT_CFG: begin
                // Settling restarts whenever AUX drops; only low cycles count toward timeout.
                if (aux_sync) begin
                    settle_d = settle_q + 32'd1;
                end else begin
                    settle_d = 32'd0;
                    tmo_d    = tmo_q + 32'd1;
                end
                if (aux_tmo) begin
                    err_d   = 2'd1;
                    state_d = (state_q == S_EXIT_CFG) ? S_DONE : S_EXIT_CFG;
                end else if (settle_done) begin
                    case (state_q)
                        S_ENTER_CFG: state_d = S_SEND_CFG;
                        S_WAIT_WR:   state_d = S_SEND_QRY;
                        default:     state_d = S_DONE;
                    endcase
                end
            end
            S_SEND_CFG: begin
                tx_data = frame_byte(tx_idx_q, par_q);
                if (can_send) begin
                    tx_use   = 1'b1;
                    gap_d    = 1'b1;
                    tx_idx_d = tx_idx_q + 3'd1;
                    if (tx_idx_q == 3'd5) state_d = S_WAIT_WR;
                end
            end
            S_SEND_QRY: begin
                tx_data = CMD_RD;
                if (can_send) begin
                    tx_use   = 1'b1;
                    gap_d    = 1'b1;
                    tx_idx_d = tx_idx_q + 3'd1;
                    if (tx_idx_q == 3'd2) state_d = S_RECV;
                end
            end
            S_RECV: begin
                tmo_d = tmo_q + 32'd1;
                if (rx_flag && rx_cnt_q < 3'd6) begin
                    rbuf_d[rx_cnt_q] = rx_data;
                    rx_cnt_d         = rx_cnt_q + 3'd1;
                end
                if (resp_tmo) begin
                    err_d   = 2'd2;
                    state_d = S_EXIT_CFG;
                end else if (rx_flag && rx_cnt_q == 3'd5) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (rbuf_q != {par_q, CMD_WR}) err_d = 2'd3;
                state_d = S_EXIT_CFG;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            settle_d = 32'd0;
            tmo_d    = 32'd0;
            tx_idx_d = 3'd0;
            gap_d    = 1'b0;
        end

        if (state_d == S_ENTER_CFG) m_d = 1'b1;
        if (state_d == S_EXIT_CFG || state_d == S_DONE || state_d == S_IDLE) m_d = 1'b0;
        if (state_d == S_DONE) ok_d = (err_d == 2'd0);

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge internal_clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            aux_s1_q <= 1'b0;
            aux_s2_q <= 1'b0;
            par_q    <= '0;
            rbuf_q   <= '0;
            rx_cnt_q <= 3'd0;
            tx_idx_q <= 3'd0;
            gap_q    <= 1'b0;
            settle_q <= 32'd0;
            tmo_q    <= 32'd0;
            m_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ok_q     <= 1'b0;
            err_q    <= 2'd0;
        end else begin
            state_q  <= state_d;
            aux_s1_q <= AUX;
            aux_s2_q <= aux_s1_q;
            par_q    <= par_d;
            rbuf_q   <= rbuf_d;
            rx_cnt_q <= rx_cnt_d;
            tx_idx_q <= tx_idx_d;
            gap_q    <= gap_d;
            settle_q <= settle_d;
            tmo_q    <= tmo_d;
            m_q      <= m_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ok_q     <= ok_d;
            err_q    <= err_d;
        end
    end

    assign M0       = m_q;
    assign M1       = m_q;
    assign cfg_busy = busy_q;
    assign cfg_done = done_q;
    assign cfg_ok   = ok_q;
    assign cfg_err  = err_q;

endmodule

// File: tb/tb_rf_host_cfg_sequencer.sv
// Scoreboard bench for rf_host_cfg_sequencer: randomized runs against a transceiver
// model (AUX pulses, echo responder) and an expected TX-byte / result queue.
module tb_rf_host_cfg_sequencer;

    localparam int SET = 20;
    localparam int AT  = 400;
    localparam int RT  = 600;

    logic       internal_clk = 1'b0;
    logic       rst, cfg_start;
    logic [7:0] cfg_addh, cfg_addl, cfg_sped, cfg_chan, cfg_option;
    logic       cfg_busy, cfg_done, cfg_ok;
    logic [1:0] cfg_err;
    logic       M0, M1, AUX;
    logic [7:0] tx_data;
    logic       tx_use, tx_full;
    logic [7:0] rx_data;
    logic       rx_flag;

    rf_host_cfg_sequencer #(
        .MODE_SETTLE_CYCLES (SET),
        .AUX_TIMEOUT_CYCLES (AT),
        .RESP_TIMEOUT_CYCLES(RT)
    ) dut (
        .internal_clk(internal_clk), .rst(rst), .cfg_start(cfg_start),
        .cfg_addh(cfg_addh), .cfg_addl(cfg_addl), .cfg_sped(cfg_sped),
        .cfg_chan(cfg_chan), .cfg_option(cfg_option),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_ok(cfg_ok), .cfg_err(cfg_err),
        .M0(M0), .M1(M1), .AUX(AUX),
        .tx_data(tx_data), .tx_use(tx_use), .tx_full(tx_full),
        .rx_data(rx_data), .rx_flag(rx_flag)
    );

    always #5 internal_clk = ~internal_clk;

    int cyc = 0;
    always @(posedge internal_clk) cyc <= cyc + 1;

    typedef struct packed {
        logic       ok;
        logic [1:0] err;
    } res_t;

    logic [7:0] exp_tx_q[$];
    res_t       exp_res_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         done_cnt = 0;

    // Transceiver-model controls and observations.
    logic       aux_stuck = 1'b0;
    logic       silent    = 1'b0;
    logic       bp_en     = 1'b0;
    logic [7:0] resp_b[6];
    int         sc_dly[$];
    logic       sc_lvl[$];
    int         rq_dly[$];
    logic [7:0] rq_byte[$];
    int         txn = 0;
    int         aux_rise_cyc = 0;
    int         c1_cyc = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void fail(string name, logic [63:0] act);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got %0h with nothing expected (cycle %0d)", name, act, cyc);
    endfunction

    task automatic sched_aux(input int lo, input logic glitch);
        sc_dly.push_back(3);  sc_lvl.push_back(1'b0);
        sc_dly.push_back(lo); sc_lvl.push_back(1'b1);
        if (glitch) begin
            sc_dly.push_back(10); sc_lvl.push_back(1'b0);
            sc_dly.push_back(5);  sc_lvl.push_back(1'b1);
        end
    endtask

    // Transceiver model: AUX busy pulses after mode changes and after the C0 frame,
    // plus an echo responder after the third C1 and a stray byte in config entry.
    initial begin : xcvr_model
        logic [1:0] pm;
        AUX = 1'b1; rx_flag = 1'b0; rx_data = 8'h00; pm = 2'b00;
        forever begin
            @(negedge internal_clk);
            rx_flag = 1'b0;
            if (rst) begin
                sc_dly.delete(); sc_lvl.delete(); rq_dly.delete(); rq_byte.delete();
                AUX = 1'b1; pm = 2'b00; txn = 0;
            end else begin
                if (tx_use) begin
                    txn++;
                    if (txn == 6) sched_aux($urandom_range(20, 100), 1'b0);
                    if (txn == 9) begin
                        c1_cyc = cyc;
                        if (!silent) begin
                            for (int i = 0; i < 6; i++) begin
                                rq_dly.push_back(i == 0 ? 4 : 3);
                                rq_byte.push_back(resp_b[i]);
                            end
                            rq_dly.push_back(3); rq_byte.push_back(8'h55);
                        end
                    end
                end
                if ({M0, M1} != pm) begin
                    pm = {M0, M1};
                    if (pm == 2'b11) begin
                        txn = 0;
                        rq_dly.push_back(2); rq_byte.push_back(8'hC0);
                    end
                    if (aux_stuck) begin
                        sc_dly.delete(); sc_lvl.delete(); AUX = 1'b0;
                    end else begin
                        sched_aux($urandom_range(20, 100), pm == 2'b11);
                    end
                end
                if (sc_dly.size() > 0) begin
                    if (sc_dly[0] <= 1) begin
                        AUX = sc_lvl[0];
                        if (sc_lvl[0]) aux_rise_cyc = cyc;
                        void'(sc_dly.pop_front()); void'(sc_lvl.pop_front());
                    end else begin
                        sc_dly[0] = sc_dly[0] - 1;
                    end
                end else if (!aux_stuck) begin
                    AUX = 1'b1;
                end
                if (rq_dly.size() > 0) begin
                    if (rq_dly[0] <= 1) begin
                        rx_flag = 1'b1;
                        rx_data = rq_byte[0];
                        void'(rq_dly.pop_front()); void'(rq_byte.pop_front());
                    end else begin
                        rq_dly[0] = rq_dly[0] - 1;
                    end
                end
            end
        end
    end

    initial begin : full_drv
        logic bp_done;
        bp_done = 1'b0;
        tx_full = 1'b0;
        forever begin
            @(posedge internal_clk); #1;
            if (txn == 0) bp_done = 1'b0;
            if (bp_en && !bp_done && txn == 3) begin
                bp_done = 1'b1;
                tx_full = 1'b1;
                repeat (50) @(posedge internal_clk);
                #1 tx_full = 1'b0;
            end else begin
                tx_full = ($urandom_range(0, 7) == 0);
            end
        end
    end

    initial begin : monitor
        logic       prev_use;
        logic [7:0] e;
        res_t       r;
        prev_use = 1'b0;
        forever begin
            @(negedge internal_clk);
            if (rst) begin
                prev_use = 1'b0;
            end else begin
                if (tx_use) begin
                    chk("no_strobe_when_full", tx_full, 0);
                    chk("strobe_gap", prev_use, 0);
                    if (exp_tx_q.size() == 0) begin
                        fail("tx_extra_byte", tx_data);
                    end else begin
                        if (exp_tx_q.size() == 9) begin
                            chk("cfg_mode_at_c0", {M0, M1}, 2'b11);
                            chk("c0_after_settle", (cyc - aux_rise_cyc) >= SET + 1, 1);
                        end
                        e = exp_tx_q.pop_front();
                        chk("tx_byte", tx_data, e);
                    end
                end
                if (cfg_done) begin
                    done_cnt++;
                    if (exp_res_q.size() == 0) begin
                        fail("unexpected_done", {cfg_ok, cfg_err});
                    end else begin
                        r = exp_res_q.pop_front();
                        chk("done_ok", cfg_ok, r.ok);
                        chk("done_err", cfg_err, r.err);
                        chk("done_mode_00", {M0, M1}, 2'b00);
                        chk("busy_in_done", cfg_busy, 1);
                    end
                end
                prev_use = tx_use;
            end
        end
    end

    // kind: 0 pass, 1 readback mismatch, 2 stuck AUX, 3 silent responder
    task automatic run(input int kind, input logic [39:0] p, input int bad_idx,
                       input logic [7:0] bad_val, input logic bp, input logic dup,
                       input logic rst_mid, input logic start_in_done);
        res_t r;
        int   start_cyc, done_cyc, d0, budget;
        logic seen;
        @(posedge internal_clk); #1;
        {cfg_option, cfg_chan, cfg_sped, cfg_addl, cfg_addh} = p;
        aux_stuck = (kind == 2);
        silent    = (kind == 3);
        bp_en     = bp;
        resp_b[0] = 8'hC0;
        for (int i = 0; i < 5; i++) resp_b[i+1] = p[8*i +: 8];
        if (kind == 1) resp_b[bad_idx] = bad_val;
        if (kind != 2) begin
            exp_tx_q.push_back(8'hC0);
            for (int i = 0; i < 5; i++) exp_tx_q.push_back(p[8*i +: 8]);
            repeat (3) exp_tx_q.push_back(8'hC1);
        end
        r.err = (kind == 2) ? 2'd1 : (kind == 3) ? 2'd2 : (kind == 1) ? 2'd3 : 2'd0;
        r.ok  = (r.err == 2'd0);
        if (!rst_mid) exp_res_q.push_back(r);
        cfg_start = 1'b1;
        start_cyc = cyc;
        @(posedge internal_clk); #1;
        cfg_start = 1'b0;
        chk("busy_after_start", cfg_busy, 1);

        if (dup) begin
            repeat (30) @(posedge internal_clk);
            #1 cfg_addh = ~p[7:0]; cfg_start = 1'b1;
            @(posedge internal_clk); #1 cfg_start = 1'b0;
        end

        if (rst_mid) begin
            budget = 0;
            while (txn < 2 && budget < 3000) begin
                @(posedge internal_clk); #1; budget++;
            end
            if (txn < 2) fail("reach_send_cfg_timeout", txn);
            rst = 1'b1;
            @(posedge internal_clk); #1;
            chk("rst_mid_m0", M0, 0);
            chk("rst_mid_m1", M1, 0);
            chk("rst_mid_tx_use", tx_use, 0);
            chk("rst_mid_busy", cfg_busy, 0);
            rst = 1'b0;
            exp_tx_q.delete();
            exp_res_q.delete();
            d0 = done_cnt;
            repeat (100) @(posedge internal_clk);
            chk("no_done_after_rst", done_cnt - d0, 0);
            bp_en = 1'b0;
            return;
        end

        seen = 1'b0;
        done_cyc = 0;
        for (int k = 0; k < 5000 && !seen; k++) begin
            @(negedge internal_clk);
            if (cfg_done) begin
                seen = 1'b1;
                done_cyc = cyc;
            end
        end
        if (!seen) begin
            fail("done_timeout", kind);
        end else begin
            if (start_in_done) cfg_start = 1'b1;
            @(posedge internal_clk); #1 cfg_start = 1'b0;
            if (kind == 3) chk("resp_tmo_min_latency", (done_cyc - c1_cyc) >= RT, 1);
            if (kind == 2) chk("aux_tmo_window",
                               (done_cyc - start_cyc) >= 2*AT && (done_cyc - start_cyc) <= 2*AT + 30, 1);
        end
        repeat (3) @(posedge internal_clk);
        #1;
        chk("idle_after_done", cfg_busy, 0);
        chk("ok_held", cfg_ok, r.ok);
        chk("err_held", cfg_err, r.err);
        chk("tx_queue_drained", exp_tx_q.size(), 0);
        exp_tx_q.delete();
        exp_res_q.delete();
        aux_stuck = 1'b0;
        bp_en = 1'b0;
        repeat (5) @(posedge internal_clk);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [39:0] p;
        int          kind, bi;
        rst = 1'b1; cfg_start = 1'b0;
        cfg_addh = 8'h00; cfg_addl = 8'h00; cfg_sped = 8'h00; cfg_chan = 8'h00; cfg_option = 8'h00;
        repeat (3) @(posedge internal_clk);
        #1;
        chk("rst_m0", M0, 0);
        chk("rst_m1", M1, 0);
        chk("rst_tx_use", tx_use, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_busy", cfg_busy, 0);
        chk("rst_done", cfg_done, 0);
        chk("rst_ok", cfg_ok, 0);
        chk("rst_err", cfg_err, 0);
        rst = 1'b0;
        repeat (5) @(posedge internal_clk);

        run(0, {8'hAA, 8'hFF, 8'h02, 8'h11, 8'h27}, 0, 8'h00, 0, 0, 0, 0);
        run(1, {8'hAA, 8'hFF, 8'h02, 8'h11, 8'h27}, 4, 8'h03, 0, 0, 0, 0);
        run(2, {8'hAA, 8'hFF, 8'h02, 8'h11, 8'h27}, 0, 8'h00, 0, 0, 0, 0);
        run(3, {8'hAA, 8'hFF, 8'h02, 8'h11, 8'h27}, 0, 8'h00, 0, 0, 0, 0);
        run(0, {8'h5C, 8'h3B, 8'h1A, 8'hC1, 8'h9E}, 0, 8'h00, 1, 1, 0, 0);
        run(0, {8'h01, 8'h02, 8'h03, 8'h04, 8'h05}, 0, 8'h00, 0, 0, 1, 0);
        run(0, {8'h10, 8'h20, 8'h30, 8'h40, 8'h50}, 0, 8'h00, 0, 0, 0, 1);

        for (int n = 0; n < 12; n++) begin
            p = {$urandom(), $urandom()};
            kind = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 3));
            bi = $urandom_range(0, 5);
            run(kind, p, bi, 8'(bi == 0 ? 8'hC0 : p[8*(bi-1) +: 8]) ^ 8'($urandom_range(1, 255)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
